// File: rtl/tlb_mmu.sv
// Joint TLB: entry array with TLBWI/TLBR/TLBP service from CP0, plus two
// independent address-translation ports (instruction fetch and data access)
// whose results are registered one cycle after the request.
module tlb_mmu #(
  parameter int TLB_ENTRIES_NUM = 16,
  localparam int IDX = $clog2(TLB_ENTRIES_NUM)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     tlb_asid,
  input  logic [IDX-1:0] tlbrw_index,
  input  logic           tlbrw_we,
  input  logic [77:0]    tlbrw_wdata,
  output logic [77:0]    tlbrw_rdata,
  input  logic [31:0]    tlbp_entry_hi,
  output logic [31:0]    tlbp_index,
  input  logic           inst_req,
  input  logic [31:0]    inst_vaddr,
  output logic           inst_valid,
  output logic [31:0]    inst_paddr,
  output logic           inst_miss,
  output logic           inst_invalid,
  output logic           inst_uncached,
  input  logic           data_req,
  input  logic [31:0]    data_vaddr,
  input  logic           data_store,
  output logic           data_valid,
  output logic [31:0]    data_paddr,
  output logic           data_miss,
  output logic           data_invalid,
  output logic           data_uncached,
  output logic           data_modified
);

  // One translation result; flags are mutually exclusive.
  typedef struct packed {
    logic [31:0] paddr;
    logic        miss;
    logic        invalid;
    logic        uncached;
    logic        modified;
  } xlat_t;

  logic [77:0] tlb_q [TLB_ENTRIES_NUM];

  logic [TLB_ENTRIES_NUM-1:0] inst_match;
  logic [TLB_ENTRIES_NUM-1:0] data_match;
  logic [TLB_ENTRIES_NUM-1:0] probe_match;
  logic [IDX-1:0]             inst_idx;
  logic [IDX-1:0]             data_idx;
  logic [IDX-1:0]             probe_idx;

  xlat_t inst_res_d, inst_res_q;
  xlat_t data_res_d, data_res_q;
  logic  inst_valid_q;
  logic  data_valid_q;

  // Entry matches when VPN2 agrees and the entry is global or ASIDs agree.
  function automatic logic entry_match(input logic [77:0] e,
                                       input logic [18:0] vpn2,
                                       input logic [7:0]  asid);
    return (e[63:45] == vpn2) && (e[0] || (e[71:64] == asid));
  endfunction

  // Lowest set bit wins when several entries match.
  function automatic logic [IDX-1:0] first_idx(input logic [TLB_ENTRIES_NUM-1:0] m);
    logic [IDX-1:0] idx;
    idx = '0;
    for (int i = TLB_ENTRIES_NUM - 1; i >= 0; i--) begin
      if (m[i]) idx = IDX'(i);
    end
    return idx;
  endfunction

  // Region decode, odd/even page select and flag generation.
  function automatic xlat_t translate(input logic [31:0] va,
                                      input logic        hit,
                                      input logic [77:0] e,
                                      input logic        store);
    xlat_t       r;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
    r   = '0;
    pfn = va[12] ? e[24:5]   : e[44:25];
    c   = va[12] ? e[74:72]  : e[77:75];
    d   = va[12] ? e[2]      : e[4];
    v   = va[12] ? e[1]      : e[3];
    if (va[31:30] == 2'b10) begin
      // kseg0 / kseg1: fixed window onto low physical memory, va[29] = uncached
      r.paddr    = {3'b000, va[28:0]};
      r.uncached = va[29];
    end else begin
      r.paddr    = {pfn, va[11:0]};
      r.uncached = hit && (c == 3'd2);
      r.miss     = !hit;
      r.invalid  = hit && !v;
      r.modified = hit && v && !d && store;
    end
    return r;
  endfunction

  // Per-entry comparators for the three lookup keys.
  for (genvar gi = 0; gi < TLB_ENTRIES_NUM; gi++) begin : g_match
    assign inst_match[gi]  = entry_match(tlb_q[gi], inst_vaddr[31:13], tlb_asid);
    assign data_match[gi]  = entry_match(tlb_q[gi], data_vaddr[31:13], tlb_asid);
    assign probe_match[gi] = entry_match(tlb_q[gi], tlbp_entry_hi[31:13],
                                         tlbp_entry_hi[7:0]);
  end

  // Priority-select the winning entry and compute next translation results.
  always_comb begin
    inst_idx   = first_idx(inst_match);
    data_idx   = first_idx(data_match);
    probe_idx  = first_idx(probe_match);
    inst_res_d = translate(inst_vaddr, |inst_match, tlb_q[inst_idx], 1'b0);
    data_res_d = translate(data_vaddr, |data_match, tlb_q[data_idx], data_store);
  end

  assign tlbrw_rdata = tlb_q[tlbrw_index];
  assign tlbp_index  = {~(|probe_match), {(31 - IDX){1'b0}}, probe_idx};

  // Entry array: cleared on reset, TLBWI writes one entry per edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TLB_ENTRIES_NUM; i++) tlb_q[i] <= '0;
    end else if (tlbrw_we) begin
      tlb_q[tlbrw_index] <= tlbrw_wdata;
    end
  end

  // Result registers: valid follows req, results hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      inst_res_q   <= '0;
      data_res_q   <= '0;
    end else begin
      inst_valid_q <= inst_req;
      data_valid_q <= data_req;
      if (inst_req) inst_res_q <= inst_res_d;
      if (data_req) data_res_q <= data_res_d;
    end
  end

  assign inst_valid    = inst_valid_q;
  assign inst_paddr    = inst_res_q.paddr;
  assign inst_miss     = inst_res_q.miss;
  assign inst_invalid  = inst_res_q.invalid;
  assign inst_uncached = inst_res_q.uncached;

  assign data_valid    = data_valid_q;
  assign data_paddr    = data_res_q.paddr;
  assign data_miss     = data_res_q.miss;
  assign data_invalid  = data_res_q.invalid;
  assign data_uncached = data_res_q.uncached;
  assign data_modified = data_res_q.modified;

  // Probe key bits between VPN2 and ASID, and the fetch-side dirty flag, carry no meaning.
  logic unused_ok;
  assign unused_ok = ^{tlbp_entry_hi[12:8], inst_res_q.modified};

endmodule

// File: tb/tb_tlb_mmu.sv
// Directed bench for tlb_mmu: a rule-level model checked every cycle plus
// literal expectations taken from the hand-worked scenarios.
module tb_tlb_mmu;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  tlb_asid;
  logic [3:0]  tlbrw_index;
  logic        tlbrw_we;
  logic [77:0] tlbrw_wdata;
  logic [77:0] tlbrw_rdata;
  logic [31:0] tlbp_entry_hi;
  logic [31:0] tlbp_index;
  logic        inst_req;
  logic [31:0] inst_vaddr;
  logic        inst_valid;
  logic [31:0] inst_paddr;
  logic        inst_miss, inst_invalid, inst_uncached;
  logic        data_req;
  logic [31:0] data_vaddr;
  logic        data_store;
  logic        data_valid;
  logic [31:0] data_paddr;
  logic        data_miss, data_invalid, data_uncached, data_modified;

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  tlb_mmu #(.TLB_ENTRIES_NUM(N)) dut (
    .clk(clk), .reset(reset), .tlb_asid(tlb_asid),
    .tlbrw_index(tlbrw_index), .tlbrw_we(tlbrw_we), .tlbrw_wdata(tlbrw_wdata),
    .tlbrw_rdata(tlbrw_rdata), .tlbp_entry_hi(tlbp_entry_hi), .tlbp_index(tlbp_index),
    .inst_req(inst_req), .inst_vaddr(inst_vaddr), .inst_valid(inst_valid),
    .inst_paddr(inst_paddr), .inst_miss(inst_miss), .inst_invalid(inst_invalid),
    .inst_uncached(inst_uncached), .data_req(data_req), .data_vaddr(data_vaddr),
    .data_store(data_store), .data_valid(data_valid), .data_paddr(data_paddr),
    .data_miss(data_miss), .data_invalid(data_invalid), .data_uncached(data_uncached),
    .data_modified(data_modified)
  );

  typedef struct packed {
    logic [31:0] paddr;
    logic        miss;
    logic        inv;
    logic        unc;
    logic        mod;
  } res_t;

  logic [77:0] m_tlb [N];
  res_t        exp_i, exp_d;
  logic        exp_iv, exp_dv;

  task automatic check(input string nm, input logic [77:0] act, input logic [77:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [77:0] mk(input logic [2:0] c0, input logic [2:0] c1,
                                     input logic [7:0] asid, input logic [18:0] vpn2,
                                     input logic [19:0] pfn0, input logic [19:0] pfn1,
                                     input logic d0, input logic v0, input logic d1,
                                     input logic v1, input logic g);
    return {c0, c1, asid, vpn2, pfn0, pfn1, d0, v0, d1, v1, g};
  endfunction

  // Index of the first entry matching (vpn2, asid), or -1.
  function automatic int find(input logic [31:0] va, input logic [7:0] asid);
    for (int i = 0; i < N; i++) begin
      if (m_tlb[i][63:45] == va[31:13] && (m_tlb[i][0] || m_tlb[i][71:64] == asid))
        return i;
    end
    return -1;
  endfunction

  function automatic res_t model(input logic [31:0] va, input logic [7:0] asid, input logic st);
    res_t r;
    int   h;
    logic [77:0] e;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d, v;
    r = '0;
    if (va[31:29] == 3'b100 || va[31:29] == 3'b101) begin
      r.paddr = va & 32'h1FFF_FFFF;
      r.unc   = (va[31:29] == 3'b101);
      return r;
    end
    h = find(va, asid);
    if (h < 0) begin
      r.miss = 1'b1;
      return r;
    end
    e   = m_tlb[h];
    pfn = va[12] ? e[24:5] : e[44:25];
    c   = va[12] ? e[74:72] : e[77:75];
    d   = va[12] ? e[2] : e[4];
    v   = va[12] ? e[1] : e[3];
    r.paddr = {pfn, va[11:0]};
    r.unc   = (c == 3'd2);
    r.inv   = !v;
    r.mod   = st && v && !d;
    return r;
  endfunction

  function automatic logic [31:0] probe_model(input logic [31:0] hi);
    int h;
    h = find(hi, hi[7:0]);
    return (h < 0) ? 32'h8000_0000 : 32'(h);
  endfunction

  // Model state: pre-write contents feed lookups sampled at the same edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) m_tlb[i] <= '0;
      exp_iv <= 1'b0;
      exp_dv <= 1'b0;
      exp_i  <= '0;
      exp_d  <= '0;
    end else begin
      exp_iv <= inst_req;
      exp_dv <= data_req;
      if (inst_req) exp_i <= model(inst_vaddr, tlb_asid, 1'b0);
      if (data_req) exp_d <= model(data_vaddr, tlb_asid, data_store);
      if (tlbrw_we) m_tlb[tlbrw_index] <= tlbrw_wdata;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_inst_valid", 78'(inst_valid), 78'(exp_iv));
      if (exp_iv) begin
        check("m_inst_miss", 78'(inst_miss), 78'(exp_i.miss));
        check("m_inst_invalid", 78'(inst_invalid), 78'(exp_i.inv));
        if (!exp_i.miss) begin
          check("m_inst_paddr", 78'(inst_paddr), 78'(exp_i.paddr));
          check("m_inst_uncached", 78'(inst_uncached), 78'(exp_i.unc));
        end
      end
      check("m_data_valid", 78'(data_valid), 78'(exp_dv));
      if (exp_dv) begin
        check("m_data_miss", 78'(data_miss), 78'(exp_d.miss));
        check("m_data_invalid", 78'(data_invalid), 78'(exp_d.inv));
        check("m_data_modified", 78'(data_modified), 78'(exp_d.mod));
        if (!exp_d.miss) begin
          check("m_data_paddr", 78'(data_paddr), 78'(exp_d.paddr));
          check("m_data_uncached", 78'(data_uncached), 78'(exp_d.unc));
        end
      end
      check("m_tlbrw_rdata", tlbrw_rdata, m_tlb[tlbrw_index]);
      check("m_tlbp_index", 78'(tlbp_index), 78'(probe_model(tlbp_entry_hi)));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [3:0] idx, input logic [77:0] w);
    tlbrw_index = idx;
    tlbrw_wdata = w;
    tlbrw_we    = 1'b1;
    step();
    tlbrw_we    = 1'b0;
  endtask

  task automatic dlook(input logic [31:0] va, input logic st);
    data_req   = 1'b1;
    data_vaddr = va;
    data_store = st;
    step();
    data_req   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [77:0] e3, e3g, e2, e7, e3n;
    tlb_asid = 8'd0; tlbrw_index = '0; tlbrw_we = 1'b0; tlbrw_wdata = '0;
    tlbp_entry_hi = '0; inst_req = 1'b0; inst_vaddr = '0;
    data_req = 1'b0; data_vaddr = '0; data_store = 1'b0;
    e3  = mk(3'd3, 3'd0, 8'h05, 19'h00400, 20'h12345, 20'h54321, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    e3g = mk(3'd3, 3'd0, 8'h05, 19'h00400, 20'h12345, 20'h54321, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    e7  = mk(3'd2, 3'd0, 8'h00, 19'h00600, 20'h77777, 20'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    e2  = mk(3'd3, 3'd0, 8'h00, 19'h00600, 20'h22222, 20'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    e3n = mk(3'd3, 3'd0, 8'h05, 19'h00400, 20'h0ABCD, 20'h54321, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    cmp_en = 1'b1;

    // Reset state
    check("rst_inst_valid", 78'(inst_valid), 78'(0));
    check("rst_data_valid", 78'(data_valid), 78'(0));
    tlbp_entry_hi = 32'h0000_0000;
    #1 check("rst_probe_entry0", 78'(tlbp_index), 78'(32'h0));
    tlbp_entry_hi = 32'h7000_0005;
    #1 check("rst_probe_none", 78'(tlbp_index), 78'(32'h8000_0000));

    // Unmapped regions
    inst_req = 1'b1; inst_vaddr = 32'h8000_1234;
    step();
    check("kseg0_valid", 78'(inst_valid), 78'(1));
    check("kseg0_paddr", 78'(inst_paddr), 78'(32'h0000_1234));
    check("kseg0_flags", 78'({inst_miss, inst_invalid, inst_uncached}), 78'(0));
    inst_vaddr = 32'hA000_0010;
    step();
    check("kseg1_paddr", 78'(inst_paddr), 78'(32'h0000_0010));
    check("kseg1_uncached", 78'(inst_uncached), 78'(1));

    // Zeroed entry 0 matches va[31:13]==0 with asid 0, elsewhere miss
    inst_vaddr = 32'h0000_0100;
    step();
    check("zero_entry_invalid", 78'({inst_miss, inst_invalid}), 78'(2'b01));
    inst_vaddr = 32'h0040_0000;
    step();
    check("zero_entry_miss", 78'({inst_miss, inst_invalid}), 78'(2'b10));
    inst_req = 1'b0;

    // Entry 3, ASID-private
    wr(4'd3, e3);
    tlb_asid = 8'h05;
    dlook(32'h0080_0ABC, 1'b0);
    check("load_paddr", 78'(data_paddr), 78'(32'h1234_5ABC));
    check("load_flags", 78'({data_miss, data_invalid, data_modified, data_uncached}), 78'(0));
    dlook(32'h0080_0ABC, 1'b1);
    check("store_modified", 78'(data_modified), 78'(1));
    tlb_asid = 8'h06;
    dlook(32'h0080_0ABC, 1'b0);
    check("asid_miss", 78'(data_miss), 78'(1));

    // Global entry
    wr(4'd3, e3g);
    dlook(32'h0080_0ABC, 1'b0);
    check("global_hit", 78'({data_miss, data_paddr}), 78'({1'b0, 32'h1234_5ABC}));
    dlook(32'h0080_1000, 1'b0);
    check("odd_invalid", 78'({data_miss, data_invalid}), 78'(2'b01));
    check("odd_paddr", 78'(data_paddr), 78'(32'h5432_1000));

    // Probe and read
    tlbp_entry_hi = 32'h0080_0005;
    tlbrw_index = 4'd3;
    #1 check("probe_hit3", 78'(tlbp_index), 78'(32'h3));
    check("read_entry3", tlbrw_rdata, e3g);
    tlbp_entry_hi = 32'h7000_0005;
    #1 check("probe_miss", 78'(tlbp_index), 78'(32'h8000_0000));

    // Multiple matches: lowest index wins
    wr(4'd7, e7);
    wr(4'd2, e2);
    dlook(32'h00C0_0010, 1'b0);
    check("multi_paddr", 78'(data_paddr), 78'(32'h2222_2010));
    check("multi_uncached", 78'(data_uncached), 78'(0));
    tlbp_entry_hi = 32'h00C0_0000;
    #1 check("multi_probe", 78'(tlbp_index), 78'(32'h2));

    // Write and lookup at the same edge
    tlb_asid = 8'h05;
    data_req = 1'b1; data_vaddr = 32'h0080_0ABC; data_store = 1'b0;
    wr(4'd3, e3n);
    check("same_edge_old", 78'(data_paddr), 78'(32'h1234_5ABC));
    step();
    data_req = 1'b0;
    check("next_new", 78'(data_paddr), 78'(32'h0ABC_DABC));

    // Asynchronous reset mid-lookup
    inst_req = 1'b1; inst_vaddr = 32'h8000_0004;
    data_req = 1'b1;
    step();
    check("pre_reset_valid", 78'({inst_valid, data_valid}), 78'(2'b11));
    #1 reset = 1'b1;
    #1 check("async_inst", 78'({inst_valid, inst_paddr, inst_uncached}), 78'(0));
    check("async_data", 78'({data_valid, data_paddr, data_modified}), 78'(0));
    check("async_entry3", tlbrw_rdata, 78'(0));
    inst_req = 1'b0; data_req = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    tlb_asid = 8'h05;
    dlook(32'h0080_0ABC, 1'b0);
    check("post_reset_miss", 78'(data_miss), 78'(1));

    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tlb_mmu.md
Name: tlb_mmu

Overview:
- Responder side of the CP0–TLB interface: holds the joint-TLB entry array and serves TLBWI writes, TLBR reads and TLBP probes from CP0.
- Also translates instruction-fetch and data-access virtual addresses into physical addresses.
- Each translation result is registered one cycle after the request and carries miss/invalid/modified flags for exception generation.
- Sits beside CP0: IF drives the instruction port and EX/MEM drives the data port.

Parameters:
- TLB_ENTRIES_NUM, 16, number of entries (power of 2). IDX = clog2(TLB_ENTRIES_NUM).

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- tlb_asid  in  8  current ASID (EntryHi[7:0])
- tlbrw_index  in  IDX  entry index for TLBWI/TLBR
- tlbrw_we  in  1  write tlbrw_wdata into entry tlbrw_index
- tlbrw_wdata  in  78  entry: [77:75]c0 [74:72]c1 [71:64]asid [63:45]vpn2 [44:25]pfn0 [24:5]pfn1 [4]d0 [3]v0 [2]d1 [1]v1 [0]G
- tlbrw_rdata  out  78  entry[tlbrw_index], same layout, combinational
- tlbp_entry_hi  in  32  probe key: [31:13]vpn2, [7:0]asid
- tlbp_index  out  32  probe result, combinational: [31]=P (1 = no match), [IDX-1:0]=matching index, others 0
- inst_req  in  1  fetch translation request
- inst_vaddr  in  32  fetch virtual address
- inst_valid  out  1  registered result valid
- inst_paddr  out  32  physical address
- inst_miss  out  1  no matching entry (mapped region only)
- inst_invalid  out  1  matching entry, selected V=0
- inst_uncached  out  1  result uncached
- data_req  in  1  data translation request
- data_vaddr  in  32  data virtual address
- data_store  in  1  access is a store
- data_valid, data_paddr, data_miss, data_invalid, data_uncached  out  1/32/1/1/1  as for the instruction port
- data_modified  out  1  store hit, V=1, D=0

Behaviour:
- Match rule, entry i: entry.vpn2 == va[31:13] && (entry.G || entry.asid == asid_key). On multiple matches, the lowest index wins.
- Odd/even page select: va[12]. 0 selects pfn0/c0/d0/v0; 1 selects pfn1/c1/d1/v1.
- Probe uses tlbp_entry_hi as va/asid_key. Lookups use tlb_asid.
- Region decode on va[31:29]:
  - 100 (kseg0): unmapped, paddr = {3'b0, va[28:0]}, cached.
  - 101 (kseg1): unmapped, same paddr, uncached.
  - All else: mapped.
  - Unmapped regions never raise miss/invalid/modified.
- Mapped paddr = {pfn, va[11:0]}. Uncached = (selected c == 3'd2).
- Flags are exclusive:
  - miss = no match.
  - invalid = match && !v.
  - modified = data port && store && match && v && !d.
  - On any flag, paddr is still driven; consumers ignore it.
- Latency: request sampled at edge T; outputs valid from T until edge T+1.
  - x_valid <= x_req every cycle.
  - Other result regs update only when x_req=1, otherwise hold.
- Write: on an edge with tlbrw_we=1, entry[tlbrw_index] <= tlbrw_wdata.
  - A lookup sampled at the same edge uses the pre-write contents.
  - tlbrw_rdata and tlbp_index reflect the new contents after the edge.
- Both lookup ports, probe, read and write operate independently in the same cycle with no stalls.
- Reset (asynchronous, any time, including mid-lookup): every entry cleared to all-zero (all V=0, G=0); all registered outputs 0.
  - After reset, any mapped lookup reports miss, except va[31:13]==0 with tlb_asid==0, which matches the zeroed entry 0 and reports invalid.
- tlbp_index with no match = 32'h8000_0000.

Test Plan:
- Reset then inst_req, inst_vaddr=0x8000_1234 -> next cycle inst_valid=1, inst_paddr=0x0000_1234, inst_uncached=0, no flags; vaddr 0xA000_0010 -> paddr 0x0000_0010, uncached=1.
- Write index 3: vpn2=0x00400 (va 0x0080_0000), asid=0x05, pfn0=0x12345, v0=1, d0=0, c0=3, G=0; tlb_asid=5, data_req load at 0x0080_0ABC -> data_paddr=0x1234_5ABC, no flags; same address as store -> data_modified=1.
- Same entry, tlb_asid=6 -> data_miss=1; rewrite with G=1 -> hit; va 0x0080_1000 (odd page, v1=0) -> data_invalid=1.
- Probe tlbp_entry_hi=0x0080_0005 -> tlbp_index=3; probe 0x7000_0005 -> 0x8000_0000; tlbrw_index=3 -> tlbrw_rdata equals written word.
- Entries 2 and 7 both match -> lookup and probe report entry 2 (probe index 2).
- Write entry 3 with a new pfn0 in the same cycle as a lookup of the same va -> result shows the old pfn, the next lookup shows the new pfn; assert reset mid-lookup -> all outputs 0 immediately, subsequent mapped lookup misses.
